avalon_pkt_sanitizer: RTL and testbench

//  Avalon-ST framing stage placed directly upstream of the packet sorter.
//  - Guarantees every packet delivered downstream has exactly one sop, one eop and 1..MAX_PKT_LEN words.
//  - Discards orphan words, truncates over-long packets, closes packets interrupted by a new sop.
//  - One-word hold register plus registered output; full throughput under back-pressure.

---
 rtl/avalon_pkg.sv | 13 +
 rtl/avalon_pipe_reg.sv | 38 +++
 rtl/avalon_pkt_sanitizer.sv | 153 +++++++++++++++
 tb/tb_avalon_pkt_sanitizer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_pkg.sv
// Shared types for the Avalon-ST packet sanitizer: FSM state encoding,
// statistics counter width and a saturating increment helper.
package avalon_pkg;

  typedef enum logic [1:0] {IDLE_S, IN_PKT_S, DROP_S} san_state_t;

  localparam int STAT_W = 16;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + STAT_W'(1) : v;
  endfunction

endpackage

// File: rtl/avalon_pipe_reg.sv
// Output stage register with valid/ready: loads a word, holds it while the
// sink stalls, clears valid once the word has been taken.
module avalon_pipe_reg
  import avalon_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_free
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  assign o_free  = !r_valid | i_ready;
  assign o_data  = r_data;
  assign o_valid = r_valid;

  // Callers only raise i_load when o_free is set, so a held word is never overwritten.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/avalon_pkt_sanitizer.sv
// Avalon-ST framing stage: drops orphan words, truncates long packets, closes
// aborted packets. Optional counters enabled by AVALON_PKT_SANITIZER_STATS_EN.
module avalon_pkt_sanitizer
  import avalon_pkg::*;
#(
  parameter int DWIDTH      = 10,
  parameter int MAX_PKT_LEN = 10
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DWIDTH-1:0] snk_data_i,
  input  logic              snk_startofpacket_i,
  input  logic              snk_endofpacket_i,
  input  logic              snk_valid_i,
  output logic              snk_ready_o,
  output logic [DWIDTH-1:0] src_data_o,
  output logic              src_startofpacket_o,
  output logic              src_endofpacket_o,
  output logic              src_valid_o,
  input  logic              src_ready_i
`ifdef AVALON_PKT_SANITIZER_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_pkt_o,
  output logic [STAT_W-1:0] stat_trunc_o,
  output logic [STAT_W-1:0] stat_drop_o
`endif
);

  localparam int LEN_W = $clog2(MAX_PKT_LEN + 1);

  typedef struct packed {
    logic [DWIDTH-1:0] data;
    logic              sop;
    logic              eop;
  } word_t;

  san_state_t       r_state, w_state_next;
  logic [LEN_W-1:0] r_len, w_len_next, w_len_inc;
  word_t            r_h, w_in_word, w_o_word, w_src_word;
  logic             r_h_valid;
  logic             w_o_free, w_snk_ready, w_accept, w_keep, w_drop, w_trunc;
  logic             w_force_h_eop, w_h_to_o, w_src_valid;

  assign w_snk_ready = !r_h_valid | w_o_free;
  assign w_accept    = snk_valid_i & w_snk_ready;
  assign w_len_inc   = r_len + LEN_W'(1);

  always_comb begin
    w_state_next   = r_state;
    w_len_next     = r_len;
    w_in_word.data = snk_data_i;
    w_in_word.sop  = snk_startofpacket_i;
    w_in_word.eop  = snk_endofpacket_i;
    w_keep         = 1'b0;
    w_drop         = 1'b0;
    w_trunc        = 1'b0;
    w_force_h_eop  = 1'b0;
    if (w_accept) begin
      if (snk_startofpacket_i) begin
        // A sop inside an open packet closes the word still waiting in H.
        w_keep        = 1'b1;
        w_force_h_eop = (r_state == IN_PKT_S);
        w_trunc       = (r_state == IN_PKT_S);
        w_state_next  = snk_endofpacket_i ? IDLE_S : IN_PKT_S;
        w_len_next    = snk_endofpacket_i ? '0 : LEN_W'(1);
      end else if (r_state == IN_PKT_S) begin
        w_keep = 1'b1;
        if (snk_endofpacket_i) begin
          w_state_next = IDLE_S;
          w_len_next   = '0;
        end else if (w_len_inc == LEN_W'(MAX_PKT_LEN)) begin
          w_in_word.eop = 1'b1;
          w_trunc       = 1'b1;
          w_state_next  = DROP_S;
          w_len_next    = '0;
        end else begin
          w_len_next = w_len_inc;
        end
      end else begin
        w_drop = 1'b1;
        if (r_state == DROP_S && snk_endofpacket_i) begin
          w_state_next = IDLE_S;
        end
      end
    end
  end

  // A non-eop word in H only moves once its successor arrives, so its eop can still be forced.
  assign w_h_to_o = r_h_valid & w_o_free & (r_h.eop | w_keep);

  always_comb begin
    w_o_word     = r_h;
    w_o_word.eop = r_h.eop | w_force_h_eop;
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_state   <= IDLE_S;
      r_len     <= '0;
      r_h       <= '0;
      r_h_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_len   <= w_len_next;
      if (w_keep) begin
        r_h       <= w_in_word;
        r_h_valid <= 1'b1;
      end else if (w_h_to_o) begin
        r_h_valid <= 1'b0;
      end
    end
  end

  avalon_pipe_reg #(
    .WIDTH (DWIDTH + 2)
  ) u_out_reg (
    .clk_i   (clk_i),
    .srst_i  (srst_i),
    .i_load  (w_h_to_o),
    .i_data  (w_o_word),
    .i_ready (src_ready_i),
    .o_data  (w_src_word),
    .o_valid (w_src_valid),
    .o_free  (w_o_free)
  );

  assign snk_ready_o         = w_snk_ready;
  assign src_data_o          = w_src_word.data;
  assign src_startofpacket_o = w_src_word.sop;
  assign src_endofpacket_o   = w_src_word.eop;
  assign src_valid_o         = w_src_valid;

`ifdef AVALON_PKT_SANITIZER_STATS_EN
  logic [STAT_W-1:0] r_stat_pkt, r_stat_trunc, r_stat_drop;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_stat_pkt   <= '0;
      r_stat_trunc <= '0;
      r_stat_drop  <= '0;
    end else begin
      r_stat_pkt   <= sat_inc(r_stat_pkt, w_src_valid & src_ready_i & w_src_word.eop);
      r_stat_trunc <= sat_inc(r_stat_trunc, w_trunc);
      r_stat_drop  <= sat_inc(r_stat_drop, w_drop);
    end
  end

  assign stat_pkt_o   = r_stat_pkt;
  assign stat_trunc_o = r_stat_trunc;
  assign stat_drop_o  = r_stat_drop;
`endif

endmodule

// File: tb/tb_avalon_pkt_sanitizer.sv
// Bench for avalon_pkt_sanitizer: packet-level reference model plus directed
// vectors with literal expectations.
module tb_avalon_pkt_sanitizer;

  localparam int DW   = 10;
  localparam int MAXL = 10;

  logic          clk = 1'b0;
  logic          srst_i;
  logic [DW-1:0] snk_data_i;
  logic          snk_startofpacket_i, snk_endofpacket_i, snk_valid_i, snk_ready_o;
  logic [DW-1:0] src_data_o;
  logic          src_startofpacket_o, src_endofpacket_o, src_valid_o, src_ready_i;
`ifdef AVALON_PKT_SANITIZER_STATS_EN
  logic [15:0]   stat_pkt_o, stat_trunc_o, stat_drop_o;
`endif

  always #5 clk = ~clk;

  avalon_pkt_sanitizer #(.DWIDTH(DW), .MAX_PKT_LEN(MAXL)) dut (
    .clk_i               (clk),
    .srst_i              (srst_i),
    .snk_data_i          (snk_data_i),
    .snk_startofpacket_i (snk_startofpacket_i),
    .snk_endofpacket_i   (snk_endofpacket_i),
    .snk_valid_i         (snk_valid_i),
    .snk_ready_o         (snk_ready_o),
    .src_data_o          (src_data_o),
    .src_startofpacket_o (src_startofpacket_o),
    .src_endofpacket_o   (src_endofpacket_o),
    .src_valid_o         (src_valid_o),
    .src_ready_i         (src_ready_i)
`ifdef AVALON_PKT_SANITIZER_STATS_EN
    ,
    .stat_pkt_o          (stat_pkt_o),
    .stat_trunc_o        (stat_trunc_o),
    .stat_drop_o         (stat_drop_o)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int acc_eop_cyc = 0;
  int m_trunc = 0;
  int m_drop  = 0;
  bit rnd_ready = 1'b0;

  logic [11:0] exp_q[$], act_q[$], cur_q[$], out_log[$];
  int          out_cyc[$];
  logic        stall_prev = 1'b0;
  logic [11:0] prev_word;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  function automatic logic [11:0] w(input logic [9:0] d, input logic s, input logic e);
    return {d, s, e};
  endfunction

  function automatic logic [11:0] log_at(input int i);
    return (i < out_log.size()) ? out_log[i] : 12'hFFF;
  endfunction

  task automatic flush_cur();
    foreach (cur_q[i]) exp_q.push_back(cur_q[i]);
    cur_q.delete();
  endtask

  task automatic close_cur();
    logic [11:0] t;
    t = cur_q.pop_back();
    t[0] = 1'b1;
    cur_q.push_back(t);
    flush_cur();
  endtask

  // Packet-level view: an open packet is a list; a non-sop word with no open packet is discarded.
  task automatic model_accept(input logic [11:0] x);
    if (x[1]) begin
      if (cur_q.size() > 0) begin
        close_cur();
        m_trunc++;
      end
      cur_q.push_back(x);
      if (x[0]) flush_cur();
    end else if (cur_q.size() == 0) begin
      m_drop++;
    end else begin
      cur_q.push_back(x);
      if (x[0]) flush_cur();
      else if (cur_q.size() == MAXL) begin
        close_cur();
        m_trunc++;
      end
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always begin
    @(posedge clk);
    #2;
    if (rnd_ready) src_ready_i = 1'($urandom_range(0, 1));
  end

  // Compare process: every output transfer is matched in order against the model stream.
  always @(negedge clk) begin
    if (srst_i) begin
      while (act_q.size() > 0) begin
        if (exp_q.size() > 0) check("rst_delivered", act_q.pop_front(), exp_q.pop_front());
        else if (cur_q.size() > 0) check("rst_partial", act_q.pop_front(), cur_q.pop_front());
        else check("rst_extra_word", act_q.pop_front(), 32'hFFFF_FFFF);
      end
      exp_q.delete();
      cur_q.delete();
      m_trunc = 0;
      m_drop  = 0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        check("stall_hold", {src_valid_o, src_data_o, src_startofpacket_o, src_endofpacket_o},
              {1'b1, prev_word});
      if (snk_valid_i && snk_ready_o) begin
        model_accept({snk_data_i, snk_startofpacket_i, snk_endofpacket_i});
        if (snk_endofpacket_i) acc_eop_cyc = cyc;
      end
      if (src_valid_o && src_ready_i) begin
        act_q.push_back({src_data_o, src_startofpacket_o, src_endofpacket_o});
        out_log.push_back({src_data_o, src_startofpacket_o, src_endofpacket_o});
        out_cyc.push_back(cyc);
      end
      while (act_q.size() > 0 && exp_q.size() > 0)
        check("stream", act_q.pop_front(), exp_q.pop_front());
      stall_prev = src_valid_o && !src_ready_i;
      prev_word  = {src_data_o, src_startofpacket_o, src_endofpacket_o};
    end
  end

  task automatic send(input logic [9:0] d, input logic s, input logic e, output int waits);
    waits = 0;
    snk_data_i = d;
    snk_startofpacket_i = s;
    snk_endofpacket_i = e;
    snk_valid_i = 1'b1;
    @(negedge clk);
    while (!snk_ready_o && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (!snk_ready_o) check("send_timeout", 32'(waits), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    snk_valid_i = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    out_log.delete();
    out_cyc.delete();
  endtask

  int wt;
  int len;
`ifdef AVALON_PKT_SANITIZER_STATS_EN
  int s_pkt, s_trunc, s_drop;
`endif

  initial begin
    srst_i = 1'b1;
    snk_data_i = '0;
    snk_startofpacket_i = 1'b0;
    snk_endofpacket_i = 1'b0;
    snk_valid_i = 1'b0;
    src_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_src_valid", 32'(src_valid_o), 32'd0);
    check("rst_src_fields", {src_data_o, src_startofpacket_o, src_endofpacket_o}, 32'd0);
    check("rst_snk_ready", 32'(snk_ready_o), 32'd1);
    @(posedge clk);
    #1;
    srst_i = 1'b0;
    idle(2);

    // 1: plain 5-word packet, eop latency
    clear_log();
`ifdef AVALON_PKT_SANITIZER_STATS_EN
    s_pkt = int'(stat_pkt_o);
`endif
    send(10'd9, 1, 0, wt);
    send(10'd3, 0, 0, wt);
    send(10'd7, 0, 0, wt);
    send(10'd1, 0, 0, wt);
    send(10'd4, 0, 1, wt);
    idle(5);
    check("t1_count", 32'(out_log.size()), 32'd5);
    check("t1_w0", log_at(0), w(10'd9, 1, 0));
    check("t1_w1", log_at(1), w(10'd3, 0, 0));
    check("t1_w2", log_at(2), w(10'd7, 0, 0));
    check("t1_w3", log_at(3), w(10'd1, 0, 0));
    check("t1_w4", log_at(4), w(10'd4, 0, 1));
    if (out_cyc.size() == 5) check("t1_eop_latency", 32'(out_cyc[4] - acc_eop_cyc), 32'd2);
    else check("t1_eop_latency_missing", 32'(out_cyc.size()), 32'd5);
`ifdef AVALON_PKT_SANITIZER_STATS_EN
    check("t1_stat_pkt", 32'(int'(stat_pkt_o) - s_pkt), 32'd1);
`endif

    // 2: 13-word packet truncated to 10, then a normal packet
    clear_log();
`ifdef AVALON_PKT_SANITIZER_STATS_EN
    s_trunc = int'(stat_trunc_o);
    s_drop  = int'(stat_drop_o);
`endif
    for (int i = 0; i < 13; i++) send(10'(32 + i), i == 0, i == 12, wt);
    send(10'h40, 1, 0, wt);
    send(10'h41, 0, 1, wt);
    idle(5);
    check("t2_count", 32'(out_log.size()), 32'd12);
    check("t2_first", log_at(0), w(10'h20, 1, 0));
    check("t2_w9_eop", log_at(9), w(10'h29, 0, 1));
    check("t2_next_sop", log_at(10), w(10'h40, 1, 0));
    check("t2_next_eop", log_at(11), w(10'h41, 0, 1));
`ifdef AVALON_PKT_SANITIZER_STATS_EN
    check("t2_stat_trunc", 32'(int'(stat_trunc_o) - s_trunc), 32'd1);
    check("t2_stat_drop", 32'(int'(stat_drop_o) - s_drop), 32'd3);
`endif

    // 3: orphan words in idle
    clear_log();
`ifdef AVALON_PKT_SANITIZER_STATS_EN
    s_drop = int'(stat_drop_o);
`endif
    send(10'h11, 0, 0, wt);
    check("t3_ready_w0", 32'(wt), 32'd0);
    send(10'h22, 0, 0, wt);
    check("t3_ready_w1", 32'(wt), 32'd0);
    idle(5);
    check("t3_no_output", 32'(out_log.size()), 32'd0);
    check("t3_ready_after", 32'(snk_ready_o), 32'd1);
`ifdef AVALON_PKT_SANITIZER_STATS_EN
    check("t3_stat_drop", 32'(int'(stat_drop_o) - s_drop), 32'd2);
`endif

    // 4: packet aborted by a new sop
    clear_log();
    send(10'h30, 1, 0, wt);
    send(10'h31, 0, 0, wt);
    send(10'h32, 0, 0, wt);
    send(10'h33, 1, 0, wt);
    send(10'h34, 0, 1, wt);
    idle(5);
    check("t4_count", 32'(out_log.size()), 32'd5);
    check("t4_x", log_at(0), w(10'h30, 1, 0));
    check("t4_a", log_at(1), w(10'h31, 0, 0));
    check("t4_b_closed", log_at(2), w(10'h32, 0, 1));
    check("t4_c", log_at(3), w(10'h33, 1, 0));
    check("t4_d", log_at(4), w(10'h34, 0, 1));

    // 5: random back-pressure, 200 packets, occasional orphans and gaps
    rnd_ready = 1'b1;
    for (int p = 0; p < 200; p++) begin
      len = $urandom_range(1, 15);
      for (int i = 0; i < len; i++)
        send(10'($urandom), i == 0, i == len - 1, wt);
      if ($urandom_range(0, 7) == 0) send(10'($urandom), 0, 0, wt);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    snk_valid_i = 1'b0;
    rnd_ready = 1'b0;
    src_ready_i = 1'b1;
    idle(30);
    check("t5_exp_drained", 32'(exp_q.size()), 32'd0);
    check("t5_act_drained", 32'(act_q.size()), 32'd0);
    check("t5_no_open_pkt", 32'(cur_q.size()), 32'd0);

    // 6: reset mid-packet with the output register full
    src_ready_i = 1'b0;
    send(10'h50, 1, 0, wt);
    send(10'h51, 0, 0, wt);
    snk_valid_i = 1'b0;
    check("t6_pre_valid", 32'(src_valid_o), 32'd1);
    srst_i = 1'b1;
    @(posedge clk);
    #1;
    srst_i = 1'b0;
    @(negedge clk);
    check("t6_src_valid", 32'(src_valid_o), 32'd0);
    check("t6_snk_ready", 32'(snk_ready_o), 32'd1);
    @(posedge clk);
    #1;
    src_ready_i = 1'b1;
    clear_log();
    send(10'h60, 1, 0, wt);
    send(10'h61, 0, 0, wt);
    send(10'h62, 0, 1, wt);
    idle(6);
    check("t6_count", 32'(out_log.size()), 32'd3);
    check("t6_w0", log_at(0), w(10'h60, 1, 0));
    check("t6_w1", log_at(1), w(10'h61, 0, 0));
    check("t6_w2", log_at(2), w(10'h62, 0, 1));
    check("end_exp_drained", 32'(exp_q.size()), 32'd0);
    check("end_act_drained", 32'(act_q.size()), 32'd0);
`ifdef AVALON_PKT_SANITIZER_STATS_EN
    check("end_stat_trunc", 32'(stat_trunc_o), 32'(m_trunc));
    check("end_stat_drop", 32'(stat_drop_o), 32'(m_drop));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
